// File: rtl/caminho_dados_param.sv
// caminho_dados_param
// -------------------
// Parameterised CPU datapath: program counter (PC), pointer register (PR),
// instruction register (IR), memory address register (MAR), memory data
// register (MDR), condition codes (CCR), an optional stack pointer (SP) and a
// small general register file. Two combinational buses feed the registers,
// and a three-state memory handshake FSM runs read and write transactions.
//
// Optional feature: define CAMINHO_DADOS_SP_EN to make the stack pointer
// functional. Without that macro the SP ports remain present, the sp_*
// strobes are ignored, sp reads as 0, and Bus1 source 3 drives 0.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   bus1_sel/bus1_reg     Bus1 source: 0 PC, 1 R[bus1_reg], 2 PR, 3 SP, else 0
//   bus2_sel              Bus2 source: 0 Bus1, 1 constant 1, 2 MDR, 3 alu_result
//   pc_load..reg_load     load/increment strobes, honoured only while idle
//   reg_dst               destination register for reg_load
//   sp_load/inc/dec       stack-pointer strobes
//   alu_result, nzvc      ALU result and flags
//   rd_start, wr_start    memory transaction requests (read wins a tie)
//   mem_ack, mem_rdata    memory completion and read data
//   mem_req, mem_we       memory request and write qualifier
//   mem_addr, mem_wdata   address (always MAR) and latched write data
//   busy                  high while a transaction is outstanding
//   ir, mdr, pc, mar, sp, pr, ccr, regs_flat   architectural state
module caminho_dados_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int NREGS  = 4,
    parameter int RS_W   = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [2:0]              bus1_sel,
    input  logic [RS_W-1:0]         bus1_reg,
    input  logic [1:0]              bus2_sel,
    input  logic                    pc_load,
    input  logic                    pc_inc,
    input  logic                    pr_inc,
    input  logic                    ir_load,
    input  logic                    mar_load,
    input  logic                    ccr_load,
    input  logic                    reg_load,
    input  logic [RS_W-1:0]         reg_dst,
    input  logic                    sp_load,
    input  logic                    sp_inc,
    input  logic                    sp_dec,
    input  logic [DATA_W-1:0]       alu_result,
    input  logic [3:0]              nzvc,
    input  logic                    rd_start,
    input  logic                    wr_start,
    input  logic                    mem_ack,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    output logic                    busy,
    output logic [DATA_W-1:0]       ir,
    output logic [DATA_W-1:0]       mdr,
    output logic [ADDR_W-1:0]       pc,
    output logic [ADDR_W-1:0]       mar,
    output logic [ADDR_W-1:0]       sp,
    output logic [DATA_W-1:0]       pr,
    output logic [3:0]              ccr,
    output logic [NREGS*DATA_W-1:0] regs_flat
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } mem_state_t;

    mem_state_t state, next_state;

    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] bus1;
    logic [DATA_W-1:0] bus2;

    // Bus1 source mux. Out-of-range register indices and unlisted selects
    // drive 0 so the bus never floats to X.
    always_comb begin
        bus1 = '0;
        case (bus1_sel)
            3'd0: bus1 = DATA_W'(pc);
            3'd1: if (int'(bus1_reg) < NREGS) bus1 = regs[bus1_reg];
            3'd2: bus1 = pr;
            // sp is tied to 0 when the stack pointer is compiled out.
            3'd3: bus1 = DATA_W'(sp);
            default: bus1 = '0;
        endcase
    end

    // Bus2 source mux.
    always_comb begin
        bus2 = '0;
        case (bus2_sel)
            2'd0: bus2 = bus1;
            2'd1: bus2 = DATA_W'(1);
            2'd2: bus2 = mdr;
            default: bus2 = alu_result;
        endcase
    end

    // Memory FSM: state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Memory FSM: next state. A read wins when both starts arrive together.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (rd_start)      next_state = RD_WAIT;
                else if (wr_start) next_state = WR_WAIT;
            end
            RD_WAIT: if (mem_ack) next_state = IDLE;
            WR_WAIT: if (mem_ack) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Memory FSM: outputs, decoded from the state alone.
    always_comb begin
        mem_req = (state == RD_WAIT) || (state == WR_WAIT);
        mem_we  = (state == WR_WAIT);
        busy    = mem_req;
    end

    assign mem_addr = mar;

    // Read data and write data latches. mem_wdata is captured only when a
    // write actually launches, so it stays stable for the whole request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mdr       <= '0;
            mem_wdata <= '0;
        end else begin
            if (state == RD_WAIT && mem_ack) mdr <= mem_rdata;
            if (state == IDLE && wr_start && !rd_start) mem_wdata <= bus1;
        end
    end

    // Architectural registers. Every strobe is frozen while busy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc  <= '0;
            pr  <= '0;
            ir  <= '0;
            mar <= '0;
            ccr <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (!busy) begin
            if (pc_load)     pc <= bus2[ADDR_W-1:0];
            else if (pc_inc) pc <= pc + ADDR_W'(1);
            if (pr_inc)   pr  <= pr + DATA_W'(1);
            if (ir_load)  ir  <= bus2;
            if (mar_load) mar <= bus2[ADDR_W-1:0];
            if (ccr_load) ccr <= nzvc;
            if (reg_load && int'(reg_dst) < NREGS) regs[reg_dst] <= bus2;
        end
    end

`ifdef CAMINHO_DADOS_SP_EN
    // Stack pointer resets to the top of the address space; load beats
    // increment, which beats decrement.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sp <= '1;
        end else if (!busy) begin
            if (sp_load)     sp <= bus2[ADDR_W-1:0];
            else if (sp_inc) sp <= sp + ADDR_W'(1);
            else if (sp_dec) sp <= sp - ADDR_W'(1);
        end
    end
`else
    // Stack pointer compiled out: ports stay, strobes are swallowed here.
    logic sp_unused;
    assign sp_unused = ^{sp_load, sp_inc, sp_dec};
    assign sp = '0;
`endif

    // Flatten the register file, R[i] at bits [i*DATA_W +: DATA_W].
    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
    end

endmodule

// File: tb/tb_caminho_dados_param.sv
// tb_caminho_dados_param
// ----------------------
// Self-checking bench for caminho_dados_param: directed scenarios followed by
// randomized register/memory operations compared against an arithmetic model
// of the architectural state.
module tb_caminho_dados_param;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int NREGS  = 4;
    localparam int RS_W   = 2;
`ifdef CAMINHO_DADOS_SP_EN
    localparam bit SP_EN = 1'b1;
`else
    localparam bit SP_EN = 1'b0;
`endif
    localparam int SP_RST = SP_EN ? 255 : 0;

    logic                    clock;
    logic                    reset;
    logic [2:0]              bus1_sel;
    logic [RS_W-1:0]         bus1_reg;
    logic [1:0]              bus2_sel;
    logic                    pc_load, pc_inc, pr_inc, ir_load, mar_load, ccr_load, reg_load;
    logic [RS_W-1:0]         reg_dst;
    logic                    sp_load, sp_inc, sp_dec;
    logic [DATA_W-1:0]       alu_result;
    logic [3:0]              nzvc;
    logic                    rd_start, wr_start, mem_ack;
    logic [DATA_W-1:0]       mem_rdata;
    logic                    mem_req, mem_we, busy;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic [DATA_W-1:0]       ir, mdr, pr;
    logic [ADDR_W-1:0]       pc, mar, sp;
    logic [3:0]              ccr;
    logic [NREGS*DATA_W-1:0] regs_flat;

    int check_count = 0;
    int pass_count  = 0;
    int fail_count  = 0;

    // Reference model state.
    int m_regs [NREGS];
    int m_pc, m_pr, m_sp, m_ir, m_mar, m_ccr, m_mdr;

    // Scratch variables for the stimulus sequence.
    int  waits;
    int  exp_wdata;
    int  rdata;
    bit  is_read;
    int  sel_tab [4];
    int  exp_tab [4];

    caminho_dados_param #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS), .RS_W(RS_W)
    ) dut (
        .clock(clock), .reset(reset),
        .bus1_sel(bus1_sel), .bus1_reg(bus1_reg), .bus2_sel(bus2_sel),
        .pc_load(pc_load), .pc_inc(pc_inc), .pr_inc(pr_inc), .ir_load(ir_load),
        .mar_load(mar_load), .ccr_load(ccr_load), .reg_load(reg_load),
        .reg_dst(reg_dst), .sp_load(sp_load), .sp_inc(sp_inc), .sp_dec(sp_dec),
        .alu_result(alu_result), .nzvc(nzvc),
        .rd_start(rd_start), .wr_start(wr_start), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
        .ir(ir), .mdr(mdr), .pc(pc), .mar(mar), .sp(sp), .pr(pr), .ccr(ccr),
        .regs_flat(regs_flat)
    );

    // Free-running clock, 10 time-unit period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Safety net so the run always ends even if the sequence stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts it, and reports tag/observed/expected on a miss.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance the given number of rising edges, landing 1 unit after the last.
    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic clearStrobes();
        bus1_sel = '0; bus1_reg = '0; bus2_sel = '0;
        pc_load = 0; pc_inc = 0; pr_inc = 0; ir_load = 0; mar_load = 0;
        ccr_load = 0; reg_load = 0; reg_dst = '0;
        sp_load = 0; sp_inc = 0; sp_dec = 0;
        alu_result = '0; nzvc = '0;
        rd_start = 0; wr_start = 0; mem_ack = 0; mem_rdata = '0;
    endtask

    task automatic modelReset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = 0;
        m_pc = 0; m_pr = 0; m_sp = SP_RST; m_ir = 0; m_mar = 0; m_ccr = 0; m_mdr = 0;
    endtask

    function automatic int modelBus1(input int sel, input int idx);
        case (sel)
            0:       return m_pc;
            1:       return (idx < NREGS) ? m_regs[idx] : 0;
            2:       return m_pr;
            3:       return SP_EN ? m_sp : 0;
            default: return 0;
        endcase
    endfunction

    function automatic int modelBus2(input int sel2, input int sel1, input int idx, input int alu);
        case (sel2)
            0:       return modelBus1(sel1, idx);
            1:       return 1;
            2:       return m_mdr;
            default: return alu;
        endcase
    endfunction

    function automatic logic [31:0] modelFlat();
        logic [31:0] f;
        f = '0;
        for (int i = 0; i < NREGS; i++) f[i*8 +: 8] = 8'(m_regs[i]);
        return f;
    endfunction

    // Random register-level strobes; memory starts and ack stay low.
    task automatic randomStrobes();
        bus1_sel = 3'($urandom_range(0, 7));
        bus1_reg = 2'($urandom_range(0, 3));
        bus2_sel = 2'($urandom_range(0, 3));
        alu_result = 8'($urandom_range(0, 255));
        nzvc = 4'($urandom_range(0, 15));
        reg_dst = 2'($urandom_range(0, 3));
        pc_load = 1'($urandom_range(0, 1)); pc_inc = 1'($urandom_range(0, 1));
        pr_inc = 1'($urandom_range(0, 1)); ir_load = 1'($urandom_range(0, 1));
        mar_load = 1'($urandom_range(0, 1)); ccr_load = 1'($urandom_range(0, 1));
        reg_load = 1'($urandom_range(0, 1));
        sp_load = 1'($urandom_range(0, 1)); sp_inc = 1'($urandom_range(0, 1));
        sp_dec = 1'($urandom_range(0, 1));
    endtask

    // Effect of the currently driven strobes on the model, for an idle edge.
    task automatic modelApply();
        int b2;
        b2 = modelBus2(int'(bus2_sel), int'(bus1_sel), int'(bus1_reg), int'(alu_result));
        if (pc_load)     m_pc = b2 % 256;
        else if (pc_inc) m_pc = (m_pc + 1) % 256;
        if (pr_inc)   m_pr = (m_pr + 1) % 256;
        if (ir_load)  m_ir = b2;
        if (mar_load) m_mar = b2 % 256;
        if (ccr_load) m_ccr = int'(nzvc);
        if (reg_load) m_regs[int'(reg_dst)] = b2;
        if (SP_EN) begin
            if (sp_load)     m_sp = b2 % 256;
            else if (sp_inc) m_sp = (m_sp + 1) % 256;
            else if (sp_dec) m_sp = (m_sp + 255) % 256;
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, "_pc"},   32'(pc),        32'(m_pc));
        checkOutput({tag, "_pr"},   32'(pr),        32'(m_pr));
        checkOutput({tag, "_sp"},   32'(sp),        32'(m_sp));
        checkOutput({tag, "_ir"},   32'(ir),        32'(m_ir));
        checkOutput({tag, "_mar"},  32'(mar),       32'(m_mar));
        checkOutput({tag, "_ccr"},  32'(ccr),       32'(m_ccr));
        checkOutput({tag, "_mdr"},  32'(mdr),       32'(m_mdr));
        checkOutput({tag, "_regs"}, regs_flat,      modelFlat());
        checkOutput({tag, "_busy"}, 32'(busy),      32'(0));
    endtask

    // Main directed + randomized sequence.
    initial begin
        clearStrobes();
        reset = 1'b1;
        applyStimulus(2);

        // Reset state, sampled while reset is still asserted.
        checkOutput("rst_pc",    32'(pc),        32'h0);
        checkOutput("rst_mar",   32'(mar),       32'h0);
        checkOutput("rst_regs",  regs_flat,      32'h0);
        checkOutput("rst_sp",    32'(sp),        32'(SP_RST));
        checkOutput("rst_busy",  32'(busy),      32'h0);
        checkOutput("rst_req",   32'(mem_req),   32'h0);
        checkOutput("rst_we",    32'(mem_we),    32'h0);
        checkOutput("rst_wdata", 32'(mem_wdata), 32'h0);
        checkOutput("rst_mdr",   32'(mdr),       32'h0);
        checkOutput("rst_ccr",   32'(ccr),       32'h0);
        reset = 1'b0;

        // Constant 1 into R2.
        bus2_sel = 2'd1; reg_load = 1; reg_dst = 2'd2;
        applyStimulus(1); clearStrobes();
        checkOutput("s1_regs", regs_flat, 32'h0001_0000);
        checkOutput("s1_sp",   32'(sp),   32'(SP_RST));

        // PC wrap and load-over-increment priority.
        bus2_sel = 2'd3; alu_result = 8'hFF; pc_load = 1;
        applyStimulus(1); clearStrobes();
        checkOutput("s2_pc_ff", 32'(pc), 32'hFF);
        pc_inc = 1;
        applyStimulus(1); clearStrobes();
        checkOutput("s2_pc_wrap", 32'(pc), 32'h00);
        bus2_sel = 2'd3; alu_result = 8'h40; pc_load = 1; pc_inc = 1;
        applyStimulus(1); clearStrobes();
        checkOutput("s2_pc_load", 32'(pc), 32'h40);

        // Read with three wait cycles; a reg_load during busy is ignored.
        bus2_sel = 2'd3; alu_result = 8'h10; mar_load = 1;
        applyStimulus(1); clearStrobes();
        checkOutput("s3_mar", 32'(mar), 32'h10);
        rd_start = 1;
        applyStimulus(1); clearStrobes();
        bus2_sel = 2'd1; reg_load = 1; reg_dst = 2'd0;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("s3_busy%0d", i), 32'(busy),     32'h1);
            checkOutput($sformatf("s3_req%0d", i),  32'(mem_req),  32'h1);
            checkOutput($sformatf("s3_we%0d", i),   32'(mem_we),   32'h0);
            checkOutput($sformatf("s3_addr%0d", i), 32'(mem_addr), 32'h10);
            applyStimulus(1);
        end
        checkOutput("s3_busy3", 32'(busy),     32'h1);
        checkOutput("s3_addr3", 32'(mem_addr), 32'h10);
        mem_ack = 1; mem_rdata = 8'hA5;
        applyStimulus(1); clearStrobes();
        checkOutput("s3_busy_end", 32'(busy),     32'h0);
        checkOutput("s3_req_end",  32'(mem_req),  32'h0);
        checkOutput("s3_mdr",      32'(mdr),      32'hA5);
        checkOutput("s3_addr_end", 32'(mem_addr), 32'h10);
        checkOutput("s3_regs",     regs_flat,     32'h0001_0000);

        // Simultaneous starts launch a read only; a lone write latches Bus1.
        bus2_sel = 2'd3; alu_result = 8'h3C; reg_load = 1; reg_dst = 2'd1;
        applyStimulus(1); clearStrobes();
        checkOutput("s4_regs", regs_flat, 32'h0001_3C00);
        bus1_sel = 3'd1; bus1_reg = 2'd1; rd_start = 1; wr_start = 1;
        applyStimulus(1); clearStrobes();
        checkOutput("s4_both_req",   32'(mem_req),   32'h1);
        checkOutput("s4_both_we",    32'(mem_we),    32'h0);
        checkOutput("s4_both_wdata", 32'(mem_wdata), 32'h0);
        mem_ack = 1; mem_rdata = 8'h5A;
        applyStimulus(1); clearStrobes();
        checkOutput("s4_rd_mdr",  32'(mdr),  32'h5A);
        checkOutput("s4_rd_busy", 32'(busy), 32'h0);
        bus1_sel = 3'd1; bus1_reg = 2'd1; wr_start = 1;
        applyStimulus(1); clearStrobes();
        for (int i = 0; i < 2; i++) begin
            alu_result = 8'($urandom_range(0, 255));
            checkOutput($sformatf("s4_wr_we%0d", i),    32'(mem_we),    32'h1);
            checkOutput($sformatf("s4_wr_req%0d", i),   32'(mem_req),   32'h1);
            checkOutput($sformatf("s4_wr_wdata%0d", i), 32'(mem_wdata), 32'h3C);
            checkOutput($sformatf("s4_wr_addr%0d", i),  32'(mem_addr),  32'h10);
            applyStimulus(1);
        end
        mem_ack = 1;
        applyStimulus(1); clearStrobes();
        checkOutput("s4_wr_req_end", 32'(mem_req), 32'h0);
        checkOutput("s4_wr_we_end",  32'(mem_we),  32'h0);
        // An ack while idle changes nothing.
        mem_ack = 1; mem_rdata = 8'hEE;
        applyStimulus(1); clearStrobes();
        checkOutput("s4_idle_ack_busy", 32'(busy), 32'h0);
        checkOutput("s4_idle_ack_mdr",  32'(mdr),  32'h5A);

        // Stack pointer behaviour (or its absence).
        reset = 1'b1;
        #1;
        checkOutput("s5_rst_sp",   32'(sp),   32'(SP_RST));
        checkOutput("s5_rst_regs", regs_flat, 32'h0);
        reset = 1'b0;
        sp_dec = 1;
        applyStimulus(2); clearStrobes();
        checkOutput("s5_sp_dec2", 32'(sp), SP_EN ? 32'hFD : 32'h0);
        bus2_sel = 2'd3; alu_result = 8'h20; sp_load = 1; sp_inc = 1; sp_dec = 1;
        applyStimulus(1); clearStrobes();
        checkOutput("s5_sp_load", 32'(sp), SP_EN ? 32'h20 : 32'h0);
        bus2_sel = 2'd3; alu_result = 8'h55; pc_load = 1;
        applyStimulus(1); clearStrobes();
        // Bus1 sources observed through the write-data latch.
        sel_tab = '{0, 5, 0, 3};
        exp_tab = '{8'h55, 0, 8'h55, SP_EN ? 8'h20 : 0};
        for (int i = 0; i < 4; i++) begin
            bus1_sel = 3'(sel_tab[i]); wr_start = 1;
            applyStimulus(1); clearStrobes();
            checkOutput($sformatf("s5_bus1_sel%0d_step%0d", sel_tab[i], i),
                        32'(mem_wdata), 32'(exp_tab[i]));
            mem_ack = 1;
            applyStimulus(1); clearStrobes();
        end

        // Reset in the middle of a read.
        bus2_sel = 2'd3; alu_result = 8'h33; mar_load = 1;
        applyStimulus(1); clearStrobes();
        rd_start = 1;
        applyStimulus(1); clearStrobes();
        mem_ack = 1; mem_rdata = 8'h99;
        applyStimulus(1); clearStrobes();
        checkOutput("s6_mdr_pre", 32'(mdr), 32'h99);
        rd_start = 1;
        applyStimulus(1); clearStrobes();
        checkOutput("s6_busy_pre", 32'(busy), 32'h1);
        applyStimulus(1);
        reset = 1'b1;
        #1;
        checkOutput("s6_rst_req",  32'(mem_req), 32'h0);
        checkOutput("s6_rst_busy", 32'(busy),    32'h0);
        checkOutput("s6_rst_mdr",  32'(mdr),     32'h0);
        #1;
        reset = 1'b0;
        mem_ack = 1; mem_rdata = 8'h77;
        applyStimulus(1); clearStrobes();
        checkOutput("s6_late_mdr",  32'(mdr),      32'h0);
        checkOutput("s6_late_busy", 32'(busy),     32'h0);
        checkOutput("s6_late_regs", regs_flat,     32'h0);
        checkOutput("s6_late_mar",  32'(mar),      32'h0);
        checkOutput("s6_late_pc",   32'(pc),       32'h0);

        // Randomized operations against the model.
        reset = 1'b1;
        #1;
        reset = 1'b0;
        modelReset();
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) != 0) begin
                randomStrobes();
                modelApply();
                applyStimulus(1); clearStrobes();
                checkModel($sformatf("rnd%0d_op", it));
            end else begin
                is_read = 1'($urandom_range(0, 1));
                waits = int'($urandom_range(0, 3));
                if (is_read) begin
                    rd_start = 1;
                    wr_start = 1'($urandom_range(0, 1));
                    exp_wdata = -1;
                end else begin
                    bus1_sel = 3'($urandom_range(0, 7));
                    bus1_reg = 2'($urandom_range(0, 3));
                    exp_wdata = modelBus1(int'(bus1_sel), int'(bus1_reg));
                    wr_start = 1;
                end
                applyStimulus(1); clearStrobes();
                for (int w = 0; w <= waits; w++) begin
                    checkOutput($sformatf("rnd%0d_busy%0d", it, w), 32'(busy),     32'h1);
                    checkOutput($sformatf("rnd%0d_we%0d", it, w),   32'(mem_we),   32'(!is_read));
                    checkOutput($sformatf("rnd%0d_addr%0d", it, w), 32'(mem_addr), 32'(m_mar));
                    if (!is_read)
                        checkOutput($sformatf("rnd%0d_wdata%0d", it, w),
                                    32'(mem_wdata), 32'(exp_wdata));
                    randomStrobes();
                    rd_start = 1'($urandom_range(0, 1));
                    wr_start = 1'($urandom_range(0, 1));
                    if (w == waits) begin
                        rdata = int'($urandom_range(0, 255));
                        mem_ack = 1; mem_rdata = 8'(rdata);
                        if (is_read) m_mdr = rdata;
                    end
                    applyStimulus(1); clearStrobes();
                end
                checkModel($sformatf("rnd%0d_mem", it));
                checkOutput($sformatf("rnd%0d_req_end", it), 32'(mem_req), 32'h0);
            end
        end

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/caminho_dados_param.md
CAMINHO_DADOS_PARAM -- requirements
Module: caminho_dados_param

Interface
REQ-001 The module SHALL expose these parameters:
- DATA_W, 8, bus/register width.
- ADDR_W, 8, PC/MAR/SP width, with ADDR_W <= DATA_W.
- NREGS, 4, number of general registers, at least 2.
- RS_W, 2, register index width, equal to clog2(NREGS).

REQ-002 The module SHALL have one clock; reset is asynchronous and active-high. Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous active-high reset.
- bus1_sel  in  3  Bus1 source: 0 PC, 1 R[bus1_reg], 2 PR, 3 SP, others 0.
- bus1_reg  in  RS_W  Bus1 register index.
- bus2_sel  in  2  Bus2 source: 0 Bus1, 1 constant 1, 2 MDR, 3 alu_result.
- pc_load, pc_inc, pr_inc, ir_load, mar_load, ccr_load, reg_load  in  1 each  load/increment strobes.
- reg_dst  in  RS_W  destination register index for reg_load.
- sp_load, sp_inc, sp_dec  in  1 each  stack-pointer strobes.
- alu_result  in  DATA_W  ALU output.
- nzvc  in  4  ALU flags.
- rd_start, wr_start  in  1 each  memory transaction requests.
- mem_ack  in  1  memory completion.
- mem_rdata  in  DATA_W  memory read data.
- mem_req, mem_we  out  1 each  memory request and write qualifier.
- mem_addr  out  ADDR_W  memory address, equal to MAR.
- mem_wdata  out  DATA_W  write-data latch.
- busy  out  1  transaction in progress.
- ir, mdr  out  DATA_W each.
- pc, mar, sp  out  ADDR_W each.
- pr  out  DATA_W.
- ccr  out  4.
- regs_flat  out  NREGS*DATA_W  register R[i] at bits [i*DATA_W +: DATA_W].

Function
REQ-003 Bus1 and Bus2 SHALL be combinational. Address-width sources SHALL be zero-extended to DATA_W. An index >= NREGS or an unlisted select SHALL drive 0; the bus SHALL never drive X.

REQ-004 On a clock edge with busy=0, each asserted load SHALL capture Bus2. PC, MAR and SP SHALL take the low ADDR_W bits; CCR SHALL take nzvc.

REQ-005 PC, PR and SP update priority SHALL be: load over inc over dec. Increment and decrement SHALL wrap modulo 2^width with no flag.

REQ-006 The memory FSM SHALL have the states IDLE, RD_WAIT and WR_WAIT. busy SHALL be 1 in both WAIT states.

REQ-007 In IDLE, rd_start SHALL enter RD_WAIT on the next edge, with mem_req=1, mem_we=0 and mem_addr=MAR.

REQ-008 In IDLE, wr_start without rd_start SHALL latch Bus1 into mem_wdata and enter WR_WAIT with mem_req=1 and mem_we=1.

REQ-009 rd_start and wr_start asserted together SHALL start a read only; the write SHALL be dropped.

REQ-010 In RD_WAIT, mem_ack SHALL latch mem_rdata into MDR and return to IDLE on the same edge; mem_req SHALL be 0 the next cycle.

REQ-011 In WR_WAIT, mem_ack SHALL return to IDLE. mem_wdata and mem_addr SHALL stay stable while mem_req=1.

REQ-012 While busy=1, all load/inc/dec strobes and new starts SHALL be ignored. mem_ack in IDLE SHALL be ignored.

REQ-013 Minimum transaction latency SHALL be 2 edges: start to WAIT, then ack to IDLE. Wait states SHALL be unbounded.

Reset
REQ-014 Asserting reset SHALL immediately force every register and output to 0, except SP, which SHALL take 2^ADDR_W-1.

REQ-015 Reset mid-transaction SHALL force IDLE and drop mem_req and busy to 0 without waiting for mem_ack. MDR SHALL be cleared.

Configuration
REQ-016 With macro CAMINHO_DADOS_SP_EN defined, SP, its strobes and bus1_sel=3 SHALL be functional.

REQ-017 Without CAMINHO_DADOS_SP_EN, the SP ports SHALL remain present, the sp_* inputs SHALL be ignored, sp SHALL be constant 0, and bus1_sel=3 SHALL drive 0.

Verification
REQ-018 The bench SHALL cover these scenarios:
- Reset, then bus2_sel=1, reg_load=1, reg_dst=2 → R2=0x01. Other registers stay 0, and sp=0xFF with SP_EN.
- pc=0xFF, then pc_inc → pc=0x00. pc_load and pc_inc together with alu_result=0x40 and bus2_sel=3 → pc=0x40.
- MAR=0x10, rd_start, mem_ack held low 3 cycles, then mem_rdata=0xA5 with ack → busy high 4 cycles, mdr=0xA5, mem_addr=0x10 throughout. A reg_load during the busy window is ignored.
- R1=0x3C, bus1_sel=1, bus1_reg=1, rd_start and wr_start asserted together → read only (mem_we=0). A later wr_start alone → mem_wdata=0x3C, mem_we=1 until ack.
- With SP_EN: sp_dec twice from reset → sp=0xFD. sp_load, sp_inc and sp_dec together with Bus2=0x20 → sp=0x20. Without the macro → sp stays 0.
- reset asserted in RD_WAIT with no ack → mem_req=0, busy=0 and mdr=0 immediately. An ack arriving after reset deasserts leaves all registers at 0.
